nonce_fifo: RTL
===============

NONCE_FIFO -- requirements
Module: nonce_fifo

Interface
- REQ-001: Parameter DEPTH, 8, number of nonce entries; SHALL be a power of two in the range 2..32.
- REQ-002: Parameter NONCE_W, 32, nonce width in bits; fixed at 32.
- REQ-003: SPI_CLK  in  1  sole clock; all state SHALL update on its rising edge.
- REQ-004: RST_N  in  1  reset, synchronous and active-low.
- REQ-005: nonce_valid  in  1  single-cycle push request from the hash engines, already synchronised to SPI_CLK.
- REQ-006: nonce_in  in  32  found nonce, qualified by nonce_valid.
- REQ-007: read_strobe  in  1  register-file read pulse.
- REQ-008: byte_sel  in  2  byte of the head entry to present; 0 is the LSB.
- REQ-009: irq_enable  in  1  interrupt mask; 1 enables the interrupt.
- REQ-010: clear_overflow  in  1  single-cycle clear of the overflow flag.
- REQ-011: data_out  out  8  selected byte of the head entry.
- REQ-012: fifo_count  out  6  number of occupied entries.
- REQ-013: fifo_empty / fifo_full  out  1 each  status flags.
- REQ-014: overflow  out  1  sticky flag set when a nonce is dropped.
- REQ-015: interrupt_out  out  1  nonce-pending interrupt to the host.

Function
- REQ-016: Storage SHALL be a circular buffer of DEPTH x 32 bits with write pointer wr_ptr, read pointer rd_ptr and occupancy counter cnt (0..DEPTH).
- REQ-017: Push: when nonce_valid=1 and cnt<DEPTH at a clock edge, the block SHALL write nonce_in to mem[wr_ptr], advance wr_ptr and increment cnt.
- REQ-018: Pop: when read_strobe=1, byte_sel=3 and cnt>0 at a clock edge, the block SHALL advance rd_ptr and decrement cnt; a strobe with byte_sel=0..2 SHALL NOT change state.
- REQ-019: Pointers SHALL wrap from DEPTH-1 to 0.
- REQ-020: data_out SHALL equal the byte_sel byte of mem[rd_ptr], decoded combinationally from registered state, and SHALL be 8'h00 when cnt=0.
- REQ-021: Latency: a nonce pushed into an empty FIFO at edge N SHALL be visible on data_out after edge N, i.e. in cycle N+1.
- REQ-022: Simultaneous push and pop with 0<cnt<=DEPTH: both SHALL be performed and cnt SHALL be unchanged; at full, the push SHALL be accepted with no overflow.
- REQ-023: Simultaneous push and pop with cnt=0: the pop SHALL be ignored and the push accepted, giving cnt=1.
- REQ-024: Push at cnt=DEPTH without a same-cycle pop: the nonce SHALL be dropped, storage and pointers SHALL be unchanged, and overflow SHALL be set to 1.
- REQ-025: overflow SHALL clear on clear_overflow=1; if a set condition occurs in the same cycle, the set SHALL win.
- REQ-026: fifo_empty SHALL be (cnt==0), fifo_full SHALL be (cnt==DEPTH), and fifo_count SHALL be cnt zero-extended; all three SHALL be registered-state derived with no extra latency.
- REQ-027: interrupt_out SHALL be registered, equal to irq_enable AND (cnt!=0) as of the previous edge, so it lags a state change by one cycle.

Reset
- REQ-028: With RST_N=0 at an edge, the block SHALL set wr_ptr=0, rd_ptr=0, cnt=0, overflow=0 and interrupt_out=0; resulting outputs SHALL be data_out=0, fifo_empty=1, fifo_full=0 and fifo_count=0.
- REQ-029: Reset SHALL take priority over a same-cycle push or pop, and a reset mid-operation SHALL discard all entries.
- REQ-030: Storage contents need not be reset.

Configuration
- REQ-031: Macro NONCE_FIFO_DEDUP_EN: when defined, a push whose nonce_in equals the last accepted nonce SHALL be silently discarded, with no write and no overflow; the last-accepted register SHALL reset invalid, so the first push after reset is always accepted.
- REQ-032: When NONCE_FIFO_DEDUP_EN is undefined, every valid push SHALL be handled per REQ-017/REQ-024 and no comparison logic SHALL exist.

Verification
- REQ-033: Reset, then push 32'hDEADBEEF -> next cycle data_out with byte_sel=0..3 is EF, BE, AD, DE; fifo_count=1; interrupt_out=1 one cycle later with irq_enable=1.
- REQ-034: Push 9 nonces with DEPTH=8 -> fifo_full=1 and overflow=1; the 9th nonce is absent; read-out order is nonces 1..8.
- REQ-035: At fifo_full, push and pop (byte_sel=3) in the same cycle -> fifo_count stays 8, overflow=0, and the new nonce is last out.
- REQ-036: Empty FIFO, simultaneous push 32'h1 and pop -> fifo_count=1 and data_out(byte 0)=01.
- REQ-037: Push 3 nonces, drive RST_N=0 for one cycle during a push -> fifo_count=0, fifo_empty=1, data_out=00, interrupt_out=0.
- REQ-038: With NONCE_FIFO_DEDUP_EN defined, push 32'h5 twice then 32'h6 -> fifo_count=2, overflow=0; with the macro undefined, the same stimulus gives fifo_count=3.

Source files
------------

// File: rtl/nonce_fifo.sv
// nonce_fifo: circular buffer of found nonces, read back one byte at a time
// through the register file. Popping happens when the host reads byte 3 of
// the head entry. Provides status flags, a sticky overflow flag and a
// registered nonce-pending interrupt.
// Optional feature: define NONCE_FIFO_DEDUP_EN to drop a push whose nonce
// equals the last accepted nonce.
module nonce_fifo #(
  parameter int DEPTH   = 8,
  parameter int NONCE_W = 32
) (
  input  logic               SPI_CLK,
  input  logic               RST_N,
  input  logic               nonce_valid,
  input  logic [NONCE_W-1:0] nonce_in,
  input  logic               read_strobe,
  input  logic [1:0]         byte_sel,
  input  logic               irq_enable,
  input  logic               clear_overflow,
  output logic [7:0]         data_out,
  output logic [5:0]         fifo_count,
  output logic               fifo_empty,
  output logic               fifo_full,
  output logic               overflow,
  output logic               interrupt_out
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [5:0] DEPTH_C = 6'(DEPTH);

  logic [NONCE_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic [5:0]         cnt_reg;
  logic               overflow_reg;
  logic               interrupt_reg;

  logic               push_req;
  logic               pop_ok;
  logic               push_ok;
  logic               drop_set;
  logic [5:0]         cnt_next;

`ifdef NONCE_FIFO_DEDUP_EN
  logic [NONCE_W-1:0] last_nonce_reg;
  logic               last_valid_reg;
  logic               is_dup;

  assign is_dup   = last_valid_reg && (nonce_in == last_nonce_reg);
  assign push_req = nonce_valid && !is_dup;

  // Remember the most recently accepted nonce; invalid after reset
  always_ff @(posedge SPI_CLK) begin
    if (!RST_N) begin
      last_valid_reg <= 1'b0;
      last_nonce_reg <= '0;
    end else if (push_ok) begin
      last_valid_reg <= 1'b1;
      last_nonce_reg <= nonce_in;
    end
  end
`else
  assign push_req = nonce_valid;
`endif

  // A pop only happens on the byte-3 read; at full a same-cycle pop frees
  // the slot, so the push is accepted rather than dropped.
  assign pop_ok   = read_strobe && (byte_sel == 2'd3) && (cnt_reg != 6'd0);
  assign push_ok  = push_req && ((cnt_reg != DEPTH_C) || pop_ok);
  assign drop_set = push_req && (cnt_reg == DEPTH_C) && !pop_ok;

  // Occupancy update: simultaneous push and pop leaves the count unchanged
  always_comb begin
    cnt_next = cnt_reg;
    if (push_ok && !pop_ok)      cnt_next = cnt_reg + 6'd1;
    else if (pop_ok && !push_ok) cnt_next = cnt_reg - 6'd1;
  end

  // Pointers, count, sticky overflow (set beats clear) and interrupt
  always_ff @(posedge SPI_CLK) begin
    if (!RST_N) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      cnt_reg       <= '0;
      overflow_reg  <= 1'b0;
      interrupt_reg <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      cnt_reg <= cnt_next;
      if (drop_set)            overflow_reg <= 1'b1;
      else if (clear_overflow) overflow_reg <= 1'b0;
      interrupt_reg <= irq_enable && (cnt_reg != 6'd0);
    end
  end

  // Storage write; contents are deliberately not reset
  always_ff @(posedge SPI_CLK) begin
    if (RST_N && push_ok) mem[wr_ptr_reg] <= nonce_in;
  end

  // Split the head entry into byte lanes for the register-file read mux
  logic [NONCE_W-1:0] head_word;
  logic [7:0]         head_lane [4];

  assign head_word = mem[rd_ptr_reg];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign head_lane[gi] = head_word[gi*8 +: 8];
    end
  endgenerate

  // Byte read-out, forced to zero when nothing is stored
  always_comb begin
    data_out = 8'h00;
    if (cnt_reg != 6'd0) data_out = head_lane[byte_sel];
  end

  assign fifo_count    = cnt_reg;
  assign fifo_empty    = (cnt_reg == 6'd0);
  assign fifo_full     = (cnt_reg == DEPTH_C);
  assign overflow      = overflow_reg;
  assign interrupt_out = interrupt_reg;

endmodule
